// File: rtl/lcd_ctrl_if.sv
// CPU-side store/status port of the LCD write controller.
interface lcd_ctrl_if;
  logic        wr_i;
  logic [31:0] wr_data_i;
  logic [31:0] status_o;

  modport master (output wr_i, output wr_data_i, input  status_o);
  modport slave  (input  wr_i, input  wr_data_i, output status_o);
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780-class LCD write controller: command FIFO replayed onto the pins with setup/EN/hold/exec timing.
// Optional power-up init sequence enabled with `define LCD_INIT_EN.
module lcd_ctrl #(
  parameter int DEPTH       = 4,
  parameter int T_SETUP_CYC = 4,
  parameter int T_EN_CYC    = 25,
  parameter int T_HOLD_CYC  = 2,
  parameter int T_EXEC_CYC  = 1850,
  parameter int T_LONG_CYC  = 76000,
  parameter int T_PWRUP_CYC = 2000000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  lcd_ctrl_if.slave  bus,
  output logic       lcd_on_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic [7:0] lcd_data_o
);

  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_EXEC
`ifdef LCD_INIT_EN
    , S_PWRUP
`endif
  } state_t;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } cmd_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_cnt, w_cnt_nxt;
  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_ovf, r_on, r_rs;
  logic [7:0]    r_data;
  logic [31:0]   r_status;

  logic          w_cmd_wr, w_full, w_push, w_pop, w_drop, w_busy, w_long, w_ld;
  cmd_t          w_ld_cmd, w_wr_cmd;
  logic          w_unused_wr_bits;

`ifdef LCD_INIT_EN
  logic          r_init, w_init_nxt;
  logic [1:0]    r_idx, w_idx_nxt;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction
`endif

  assign w_unused_wr_bits = ^{bus.wr_data_i[29:10], bus.wr_data_i[8]};

  assign w_wr_cmd = '{rs: bus.wr_data_i[9], data: bus.wr_data_i[7:0]};
  assign w_cmd_wr = bus.wr_i & ~bus.wr_data_i[30];
  assign w_full   = (r_count == FULL_CNT);
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push   = w_cmd_wr & (~w_full | w_pop);
  assign w_drop   = w_cmd_wr & w_full & ~w_pop;
  assign w_busy   = (r_state != S_IDLE) | (r_count != '0);
  // Only 0x01 (clear display) takes the long execution wait.
  assign w_long   = ~r_rs & (r_data[7:1] == 7'd0) & (r_data != 8'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = (r_cnt == '0) ? '0 : r_cnt - 32'd1;
    w_pop       = 1'b0;
    w_ld        = 1'b0;
    w_ld_cmd    = r_mem[r_rptr];
`ifdef LCD_INIT_EN
    w_init_nxt  = r_init;
    w_idx_nxt   = r_idx;
`endif
    unique case (r_state)
      S_IDLE: if (r_count != '0) begin
        w_pop       = 1'b1;
        w_ld        = 1'b1;
        w_state_nxt = S_SETUP;
        w_cnt_nxt   = 32'(T_SETUP_CYC - 1);
      end
      S_SETUP: if (r_cnt == '0) begin
        w_state_nxt = S_PULSE;
        w_cnt_nxt   = 32'(T_EN_CYC - 1);
      end
      S_PULSE: if (r_cnt == '0) begin
        w_state_nxt = S_HOLD;
        w_cnt_nxt   = 32'(T_HOLD_CYC - 1);
      end
      S_HOLD: if (r_cnt == '0) begin
        w_state_nxt = S_EXEC;
        w_cnt_nxt   = w_long ? 32'(T_LONG_CYC - 1) : 32'(T_EXEC_CYC - 1);
      end
      S_EXEC: if (r_cnt == '0) begin
`ifdef LCD_INIT_EN
        if (r_init && r_idx != 2'd3) begin
          w_idx_nxt   = r_idx + 2'd1;
          w_ld        = 1'b1;
          w_ld_cmd    = '{rs: 1'b0, data: init_cmd(r_idx + 2'd1)};
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = 32'(T_SETUP_CYC - 1);
        end else begin
          w_init_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
`else
        w_state_nxt = S_IDLE;
`endif
      end
`ifdef LCD_INIT_EN
      S_PWRUP: if (r_cnt == '0) begin
        w_ld        = 1'b1;
        w_ld_cmd    = '{rs: 1'b0, data: init_cmd(2'd0)};
        w_state_nxt = S_SETUP;
        w_cnt_nxt   = 32'(T_SETUP_CYC - 1);
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
`ifdef LCD_INIT_EN
      r_state <= S_PWRUP;
      r_cnt   <= 32'(T_PWRUP_CYC - 1);
      r_init  <= 1'b1;
      r_idx   <= 2'd0;
`else
      r_state <= S_IDLE;
      r_cnt   <= '0;
`endif
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_on     <= 1'b0;
      r_rs     <= 1'b0;
      r_data   <= 8'd0;
      r_status <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
`ifdef LCD_INIT_EN
      r_init  <= w_init_nxt;
      r_idx   <= w_idx_nxt;
`endif
      if (bus.wr_i) r_on <= bus.wr_data_i[31];
      if (bus.wr_i && bus.wr_data_i[30]) r_ovf <= 1'b0;
      else if (w_drop)                   r_ovf <= 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_ld) begin
        r_rs   <= w_ld_cmd.rs;
        r_data <= w_ld_cmd.data;
      end
      // Count field is 4 bits wide; at DEPTH=16 a full queue reads 0 there, full bit still set.
      r_status <= {24'd0, 4'(r_count), 1'b0, r_ovf, w_full, w_busy};
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= w_wr_cmd;
  end

  assign bus.status_o = r_status;
  assign lcd_on_o     = r_on;
  assign lcd_rs_o     = r_rs;
  assign lcd_rw_o     = 1'b0;
  assign lcd_en_o     = (r_state == S_PULSE);
  assign lcd_data_o   = r_data;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing; define LCD_INIT_EN to also cover the init sequence.
module tb_lcd_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o;
  logic [7:0] lcd_data_o;
  int         n_pass = 0;
  int         n_chk  = 0;

  lcd_ctrl_if bus();

  lcd_ctrl #(
    .DEPTH(4), .T_SETUP_CYC(2), .T_EN_CYC(3), .T_HOLD_CYC(1),
    .T_EXEC_CYC(5), .T_LONG_CYC(20), .T_PWRUP_CYC(10)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus),
    .lcd_on_o(lcd_on_o), .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o),
    .lcd_en_o(lcd_en_o), .lcd_data_o(lcd_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [31:0] d);
    bus.wr_i      = 1'b1;
    bus.wr_data_i = d;
    tick();
    bus.wr_i      = 1'b0;
    bus.wr_data_i = '0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_st;
    tick();
    tick();
    n_chk++;
    if ({bus.status_o, lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_data_o} !== 44'd0)
      $display("FAIL reset_outputs: got status=%h on=%b rs=%b rw=%b en=%b data=%h, want all 0",
               bus.status_o, lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_data_o);
    else n_pass++;
    rst_ni = 1'b1;
    tick(); tick(); tick();
`ifdef LCD_INIT_EN
    exp_st = 32'h1;
`else
    exp_st = 32'h0;
`endif
    n_chk++;
    if (bus.status_o !== exp_st)
      $display("FAIL reset_status_after_release: got %h want %h", bus.status_o, exp_st);
    else n_pass++;
  endtask

`ifdef LCD_INIT_EN
  task automatic test_init();
    logic [8:0] cap [8];
    logic [8:0] exp_cmd [5];
    int         np;
    logic       prev_en, early_en;
    exp_cmd = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h141};
    np = 0; prev_en = 1'b0; early_en = 1'b0;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      if (c == 2) wr(32'h0000_0241);
      else        tick();
      if (c <= 10 && lcd_en_o) early_en = 1'b1;
      if (lcd_en_o && !prev_en) begin
        if (np < 8) cap[np] = {lcd_rs_o, lcd_data_o};
        np++;
      end
      prev_en = lcd_en_o;
    end
    n_chk++;
    if (early_en !== 1'b0) $display("FAIL init_pwrup_wait: got EN during power-up want none");
    else n_pass++;
    n_chk++;
    if (np != 5) $display("FAIL init_pulse_count: got %0d want 5", np);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (i >= np || cap[i] !== exp_cmd[i])
        $display("FAIL init_cmd_%0d: got %h want %h", i, (i < np) ? cap[i] : 9'h1FF, exp_cmd[i]);
      else n_pass++;
    end
    n_chk++;
    if (bus.status_o !== 32'h0) $display("FAIL init_final_status: got %h want 0", bus.status_o);
    else n_pass++;
  endtask
`endif

  task automatic test_single();
    logic [31:0] en_m, busy_m;
    logic        on1;
    logic [8:0]  pins2;
    en_m = '0; busy_m = '0; on1 = 1'b0; pins2 = '0;
    wr(32'h8000_0241);
    for (int k = 1; k <= 20; k++) begin
      en_m[k]   = lcd_en_o;
      busy_m[k] = bus.status_o[0];
      if (k == 1) on1 = lcd_on_o;
      if (k == 2) pins2 = {lcd_rs_o, lcd_data_o};
      tick();
    end
    n_chk++;
    if (on1 !== 1'b1) $display("FAIL single_on: got %b want 1", on1);
    else n_pass++;
    n_chk++;
    if (pins2 !== 9'h141) $display("FAIL single_pins: got %h want 141", pins2);
    else n_pass++;
    n_chk++;
    if (en_m !== 32'h0000_0070) $display("FAIL single_en_window: got %h want 00000070", en_m);
    else n_pass++;
    n_chk++;
    if (busy_m !== 32'h0000_3FFC) $display("FAIL single_busy_window: got %h want 00003ffc", busy_m);
    else n_pass++;
    n_chk++;
    if (bus.status_o !== 32'h0) $display("FAIL single_idle_status: got %h want 0", bus.status_o);
    else n_pass++;
  endtask

  task automatic test_clear();
    logic [39:0] en_m, busy_m;
    logic [8:0]  pins2;
    en_m = '0; busy_m = '0; pins2 = '0;
    wr(32'h0000_0001);
    for (int k = 1; k <= 35; k++) begin
      en_m[k]   = lcd_en_o;
      busy_m[k] = bus.status_o[0];
      if (k == 2) pins2 = {lcd_rs_o, lcd_data_o};
      tick();
    end
    n_chk++;
    if (pins2 !== 9'h001 || lcd_on_o !== 1'b0)
      $display("FAIL clear_pins: got pins=%h on=%b want 001 on=0", pins2, lcd_on_o);
    else n_pass++;
    n_chk++;
    if (en_m !== 40'h00_0000_0070) $display("FAIL clear_en_window: got %h want 0000000070", en_m);
    else n_pass++;
    n_chk++;
    if (busy_m !== 40'h00_1FFF_FFFC) $display("FAIL clear_busy_long_exec: got %h want 001ffffffc", busy_m);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [8:0] cap [8];
    int         np;
    logic       prev_en;
    logic [31:0] st7, st9, st10;
    np = 0; prev_en = 1'b0; st7 = '0; st9 = '0; st10 = '0;
    for (int k = 0; k < 100; k++) begin
      bus.wr_i      = (k < 6) || (k == 8);
      bus.wr_data_i = (k == 8) ? 32'h4000_0000 : 32'h0000_0241 + 32'(k);
      tick();
      bus.wr_i      = 1'b0;
      bus.wr_data_i = '0;
      if (k + 1 == 7)  st7  = bus.status_o;
      if (k + 1 == 9)  st9  = bus.status_o;
      if (k + 1 == 10) st10 = bus.status_o;
      if (lcd_en_o && !prev_en) begin
        if (np < 8) cap[np] = {lcd_rs_o, lcd_data_o};
        np++;
      end
      prev_en = lcd_en_o;
    end
    n_chk++;
    if (st7 !== 32'h47) $display("FAIL ovf_full_status: got %h want 00000047", st7);
    else n_pass++;
    n_chk++;
    if (st9 !== 32'h47) $display("FAIL ovf_sticky: got %h want 00000047", st9);
    else n_pass++;
    n_chk++;
    if (st10 !== 32'h43) $display("FAIL ovf_clear_count_kept: got %h want 00000043", st10);
    else n_pass++;
    n_chk++;
    if (np != 5) $display("FAIL ovf_pulse_count: got %0d want 5", np);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (i >= np || cap[i] !== 9'h141 + 9'(i))
        $display("FAIL ovf_order_%0d: got %h want %h", i, (i < np) ? cap[i] : 9'h1FF, 9'h141 + 9'(i));
      else n_pass++;
    end
    n_chk++;
    if (bus.status_o !== 32'h0) $display("FAIL ovf_final_status: got %h want 0", bus.status_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int   waited, np, exp_np;
    logic prev_en;
    for (int i = 0; i < 3; i++) wr(32'h8000_0255 + 32'(i));
    waited = 0;
    while (!lcd_en_o && waited < 20) begin
      tick();
      waited++;
    end
    n_chk++;
    if (!lcd_en_o) $display("FAIL mid_reset_wait_en: got no EN within 20 cycles want EN=1");
    else n_pass++;
    #2;
    rst_ni = 1'b0;
    #1;
    n_chk++;
    if ({lcd_en_o, lcd_rs_o, lcd_on_o, lcd_data_o} !== 11'd0)
      $display("FAIL mid_reset_pins: got en=%b rs=%b on=%b data=%h want all 0",
               lcd_en_o, lcd_rs_o, lcd_on_o, lcd_data_o);
    else n_pass++;
    tick(); tick();
    rst_ni = 1'b1;
`ifdef LCD_INIT_EN
    exp_np = 4;
`else
    exp_np = 0;
`endif
    np = 0; prev_en = 1'b0;
    for (int k = 0; k < 120; k++) begin
      tick();
      if (lcd_en_o && !prev_en) np++;
      prev_en = lcd_en_o;
    end
    n_chk++;
    if (np != exp_np) $display("FAIL mid_reset_discard: got %0d pulses want %0d", np, exp_np);
    else n_pass++;
    n_chk++;
    if (bus.status_o !== 32'h0) $display("FAIL mid_reset_status: got %h want 0", bus.status_o);
    else n_pass++;
  endtask

  initial begin
    bus.wr_i      = 1'b0;
    bus.wr_data_i = '0;
    test_reset();
`ifdef LCD_INIT_EN
    test_init();
`endif
    test_single();
    test_clear();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
